out_arbiter: RTL

OUT_ARBITER -- requirements
Module: out_arbiter

---
 rtl/out_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/out_arbiter.sv
// rtl/out_arbiter.sv - wormhole output-port arbiter: round-robin head grant, flit forwarding head to tail
module out_arbiter #(
    parameter int N    = 4,
    parameter int PORT = 0,
    parameter int PKTW = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          in_empty,
    input  logic [N*(PKTW+1)-1:0] in_pkt,
    output logic [N-1:0]          in_re,
    input  logic                  out_full,
    output logic                  out_we,
    output logic [PKTW:0]         out_pkt,
    output logic [N-1:0]          grant,
    output logic                  busy
);

    localparam int W  = PKTW + 1;
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] DEST      = 2'(PORT);
    localparam logic [1:0] TYPE_NULL = 2'b00;
    localparam logic [1:0] TYPE_HEAD = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    typedef enum logic {IDLE, XFER} state_t;

    state_t        state;
    logic [GW-1:0] gnt;
    logic [GW-1:0] last;

    logic [N-1:0]  req;
    logic          found;
    logic [GW-1:0] win;
    logic [W-1:0]  front;
    logic [1:0]    ftype;
    logic          tail_move;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i] = !in_empty[i]
                  && (in_pkt[i*W + PKTW -: 2] == TYPE_HEAD)
                  && (in_pkt[i*W +: 2] == DEST);
        end
    end

    // Scan starts just after the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last) + k) % N]) begin
                found = 1'b1;
                win   = GW'((int'(last) + k) % N);
            end
        end
    end

    assign front = in_pkt[int'(gnt)*W +: W];
    assign ftype = front[PKTW -: 2];

    // Null flits are dropped even when downstream is full; they never reach it.
    always_comb begin
        in_re   = '0;
        out_we  = 1'b0;
        out_pkt = '0;
        if (state == XFER && !in_empty[gnt]) begin
            if (ftype == TYPE_NULL) begin
                in_re[gnt] = 1'b1;
            end else if (!out_full) begin
                in_re[gnt] = 1'b1;
                out_we     = 1'b1;
                out_pkt    = front;
            end
        end
    end

    assign tail_move = (state == XFER) && !in_empty[gnt] && !out_full
                    && (ftype == TYPE_TAIL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= GW'(N - 1);
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= XFER;
                        gnt   <= win;
                        grant <= {{(N-1){1'b0}}, 1'b1} << win;
                        busy  <= 1'b1;
                    end
                end
                XFER: begin
                    if (tail_move) begin
                        state <= IDLE;
                        last  <= gnt;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
